// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding and defaults also used by the transmitter.
package uart_pkg;

  localparam int unsigned UART_BIT_TIME_DEFAULT = 2600;
  localparam int unsigned UART_DATA_BITS        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte holding-register interface between the UART receiver and its consumer.
interface uart_rx_if;

  logic       rdrf_clr;
  logic [7:0] rx_data;
  logic       rdrf;
  logic       fe;
  logic       oe;
  logic       busy;

  // Consumer side: acknowledges bytes, reads data and status.
  modport master (
    output rdrf_clr,
    input  rx_data, rdrf, fe, oe, busy
  );

  // Receiver side.
  modport slave (
    input  rdrf_clr,
    output rx_data, rdrf, fe, oe, busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with rdrf/fe/oe holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote of rx_s at every decision point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_TIME = UART_BIT_TIME_DEFAULT,
    parameter int unsigned HALF_BIT = BIT_TIME / 2
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        rxd,
    uart_rx_if.slave    bus
);

    localparam logic [11:0] HALF_LAST = 12'(HALF_BIT - 1);
    localparam logic [11:0] BIT_LAST  = 12'(BIT_TIME - 1);
    localparam logic [11:0] BIT_END   = 12'(BIT_TIME);
    localparam logic [3:0]  LAST_BIT  = 4'(UART_DATA_BITS - 1);

    uart_state_e state, state_nxt;
    logic [11:0] baud_cnt, baud_nxt;
    logic [3:0]  bit_cnt, bit_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        stop_bit, stop_nxt;
    logic        rx_s, rx_d, sample;
    logic        busy, byte_ok, frame_err;
    logic [7:0]  rx_data;
    logic        rdrf, fe, oe;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (clr_n),
        .d     (rxd),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) rx_d <= 1'b1;
        else        rx_d <= rx_s;
    end

`ifdef UART_RX_MAJORITY_EN
    // rx_d already holds rx_s one cycle back; only the two-back tap is extra.
    logic rx_h2;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) rx_h2 <= 1'b1;
        else        rx_h2 <= rx_d;
    end

    assign sample = maj3(rx_s, rx_d, rx_h2);

    if (BIT_TIME < 6) begin : g_bit_time_check
        $error("uart_rx: BIT_TIME must be >= 6 with majority sampling");
    end
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            stop_bit <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            stop_bit <= stop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        stop_nxt  = stop_bit;
        unique case (state)
            IDLE: begin
                // Edge-only detection also keeps a held-low break from restarting a frame.
                if (rx_d && !rx_s) begin
                    state_nxt = START;
                    baud_nxt  = '0;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    if (!sample) begin
                        state_nxt = DATA;
                        baud_nxt  = '0;
                        bit_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + 12'd1;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    shift_nxt = {sample, shift[7:1]};
                    bit_nxt   = bit_cnt + 4'd1;
                    baud_nxt  = '0;
                    if (bit_cnt == LAST_BIT) state_nxt = STOP;
                end else begin
                    baud_nxt = baud_cnt + 12'd1;
                end
            end
            STOP: begin
                // Stop sample is registered, then applied one cycle later while still busy.
                if (baud_cnt == BIT_END) begin
                    state_nxt = IDLE;
                end else begin
                    if (baud_cnt == BIT_LAST) stop_nxt = sample;
                    baud_nxt = baud_cnt + 12'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        byte_ok   = (state == STOP) && (baud_cnt == BIT_END) && stop_bit;
        frame_err = (state == STOP) && (baud_cnt == BIT_END) && !stop_bit;
    end

    // A set in the same cycle as rdrf_clr wins; an acknowledged byte never raises oe.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rx_data <= '0;
            rdrf    <= 1'b0;
            fe      <= 1'b0;
            oe      <= 1'b0;
        end else begin
            if (byte_ok) rx_data <= shift;
            rdrf <= byte_ok | (rdrf & ~bus.rdrf_clr);
            fe   <= frame_err | (fe & ~bus.rdrf_clr);
            oe   <= (byte_ok & rdrf & ~bus.rdrf_clr) | (oe & ~bus.rdrf_clr);
        end
    end

    assign bus.rx_data = rx_data;
    assign bus.rdrf    = rdrf;
    assign bus.fe      = fe;
    assign bus.oe      = oe;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BIT_TIME=16; majority-vote scenario only when UART_RX_MAJORITY_EN is set.
module tb_uart_rx;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic rxd = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    int   rise_edge;
    logic busy_at_rise, busy_before, last_busy, prev_rdrf;

    uart_rx_if bus_if ();

    uart_rx #(.BIT_TIME(16)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .rxd   (rxd),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic line_val(input int c, input logic [7:0] data,
                                      input logic stop_val, input bit spike);
        int   idx;
        logic v;
        idx = c / 16;
        if (idx == 0)      v = 1'b0;
        else if (idx <= 8) v = data[idx-1];
        else               v = stop_val;
        if (spike && (c % 16 == 8)) v = ~v;
        return v;
    endfunction

    // Frame starts right after the next posedge (cycle 0); rdrf rise edge is logged.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input bit spike, input int n_cycles);
        @(posedge clk); #1;
        rxd       = line_val(0, data, stop_val, spike);
        rise_edge = -1;
        prev_rdrf = bus_if.rdrf;
        last_busy = bus_if.busy;
        for (int c = 1; c < n_cycles; c++) begin
            @(posedge clk); #1;
            if (!prev_rdrf && bus_if.rdrf && rise_edge < 0) begin
                rise_edge    = c;
                busy_at_rise = bus_if.busy;
                busy_before  = last_busy;
            end
            last_busy = bus_if.busy;
            prev_rdrf = bus_if.rdrf;
            rxd = line_val(c, data, stop_val, spike);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        bus_if.rdrf_clr = 1'b1;
        @(posedge clk); #1;
        bus_if.rdrf_clr = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus_if.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h exp 00", bus_if.rx_data); end
        n_cmp++; if (bus_if.rdrf !== 1'b0) begin n_err++; $display("FAIL reset_rdrf: got %b exp 0", bus_if.rdrf); end
        n_cmp++; if (bus_if.fe !== 1'b0) begin n_err++; $display("FAIL reset_fe: got %b exp 0", bus_if.fe); end
        n_cmp++; if (bus_if.oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b exp 0", bus_if.oe); end
        clr_n = 1'b1;
        idle(10);
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", bus_if.busy); end
    endtask

    task automatic test_single_byte();
        send_frame(8'h55, 1'b1, 1'b0, 160);
        idle(20);
        n_cmp++; if (rise_edge != 156) begin n_err++; $display("FAIL single_rdrf_latency: got %0d exp 156", rise_edge); end
        n_cmp++; if (busy_at_rise !== 1'b0) begin n_err++; $display("FAIL single_busy_at_rise: got %b exp 0", busy_at_rise); end
        n_cmp++; if (busy_before !== 1'b1) begin n_err++; $display("FAIL single_busy_before_rise: got %b exp 1", busy_before); end
        n_cmp++; if (bus_if.rx_data !== 8'h55) begin n_err++; $display("FAIL single_rx_data: got %h exp 55", bus_if.rx_data); end
        n_cmp++; if (bus_if.fe !== 1'b0) begin n_err++; $display("FAIL single_fe: got %b exp 0", bus_if.fe); end
        n_cmp++; if (bus_if.oe !== 1'b0) begin n_err++; $display("FAIL single_oe: got %b exp 0", bus_if.oe); end
        pulse_clr();
        n_cmp++; if (bus_if.rdrf !== 1'b0) begin n_err++; $display("FAIL single_clr_rdrf: got %b exp 0", bus_if.rdrf); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'hA3, 1'b1, 1'b0, 160);
        send_frame(8'h0F, 1'b1, 1'b0, 160);
        idle(20);
        n_cmp++; if (bus_if.rx_data !== 8'h0F) begin n_err++; $display("FAIL b2b_rx_data: got %h exp 0f", bus_if.rx_data); end
        n_cmp++; if (bus_if.rdrf !== 1'b1) begin n_err++; $display("FAIL b2b_rdrf: got %b exp 1", bus_if.rdrf); end
        n_cmp++; if (bus_if.oe !== 1'b1) begin n_err++; $display("FAIL b2b_oe: got %b exp 1", bus_if.oe); end
        n_cmp++; if (bus_if.fe !== 1'b0) begin n_err++; $display("FAIL b2b_fe: got %b exp 0", bus_if.fe); end
        pulse_clr();
        n_cmp++; if (bus_if.rdrf !== 1'b0) begin n_err++; $display("FAIL b2b_clr_rdrf: got %b exp 0", bus_if.rdrf); end
        n_cmp++; if (bus_if.fe !== 1'b0) begin n_err++; $display("FAIL b2b_clr_fe: got %b exp 0", bus_if.fe); end
        n_cmp++; if (bus_if.oe !== 1'b0) begin n_err++; $display("FAIL b2b_clr_oe: got %b exp 0", bus_if.oe); end
        n_cmp++; if (bus_if.rx_data !== 8'h0F) begin n_err++; $display("FAIL b2b_clr_keeps_data: got %h exp 0f", bus_if.rx_data); end
    endtask

    task automatic test_break();
        int busy_seen;
        idle(20);
        send_frame(8'h3C, 1'b0, 1'b0, 160);
        @(posedge clk); #1;
        n_cmp++; if (bus_if.fe !== 1'b1) begin n_err++; $display("FAIL break_fe: got %b exp 1", bus_if.fe); end
        n_cmp++; if (bus_if.rdrf !== 1'b0) begin n_err++; $display("FAIL break_rdrf: got %b exp 0", bus_if.rdrf); end
        n_cmp++; if (bus_if.rx_data !== 8'h0F) begin n_err++; $display("FAIL break_rx_data_kept: got %h exp 0f", bus_if.rx_data); end
        busy_seen = 0;
        rxd = 1'b0;
        repeat (40 * 16) begin
            @(posedge clk); #1;
            if (bus_if.busy) busy_seen++;
        end
        rxd = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus_if.busy) busy_seen++;
        end
        n_cmp++; if (busy_seen != 0) begin n_err++; $display("FAIL break_no_restart: got %0d busy cycles exp 0", busy_seen); end
        n_cmp++; if (bus_if.fe !== 1'b1) begin n_err++; $display("FAIL break_fe_sticky: got %b exp 1", bus_if.fe); end
        pulse_clr();
        n_cmp++; if (bus_if.fe !== 1'b0) begin n_err++; $display("FAIL break_clr_fe: got %b exp 0", bus_if.fe); end
    endtask

    task automatic test_glitch();
        int saw_busy;
        saw_busy = 0;
        idle(5);
        rxd = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rxd = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus_if.busy) saw_busy = 1;
        end
        n_cmp++; if (saw_busy != 1) begin n_err++; $display("FAIL glitch_start_entered: got %0d exp 1", saw_busy); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL glitch_back_idle: got %b exp 0", bus_if.busy); end
        n_cmp++; if ({bus_if.rdrf, bus_if.fe, bus_if.oe} !== 3'b000) begin n_err++; $display("FAIL glitch_flags: got %b exp 000", {bus_if.rdrf, bus_if.fe, bus_if.oe}); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'hC6, 1'b1, 1'b0, 80);
        clr_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b exp 0", bus_if.busy); end
        n_cmp++; if (bus_if.rx_data !== 8'h00) begin n_err++; $display("FAIL midrst_rx_data: got %h exp 00", bus_if.rx_data); end
        clr_n = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, 1'b0, 160);
        idle(20);
        n_cmp++; if (bus_if.rx_data !== 8'h81) begin n_err++; $display("FAIL midrst_new_data: got %h exp 81", bus_if.rx_data); end
        n_cmp++; if (bus_if.rdrf !== 1'b1) begin n_err++; $display("FAIL midrst_rdrf: got %b exp 1", bus_if.rdrf); end
        n_cmp++; if ({bus_if.fe, bus_if.oe} !== 2'b00) begin n_err++; $display("FAIL midrst_fe_oe: got %b exp 00", {bus_if.fe, bus_if.oe}); end
        pulse_clr();
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        idle(20);
        send_frame(8'hF0, 1'b1, 1'b1, 160);
        idle(20);
        n_cmp++; if (bus_if.rx_data !== 8'hF0) begin n_err++; $display("FAIL maj_rx_data: got %h exp f0", bus_if.rx_data); end
        n_cmp++; if (bus_if.fe !== 1'b0) begin n_err++; $display("FAIL maj_fe: got %b exp 0", bus_if.fe); end
        n_cmp++; if (bus_if.rdrf !== 1'b1) begin n_err++; $display("FAIL maj_rdrf: got %b exp 1", bus_if.rdrf); end
        pulse_clr();
    endtask
`endif

    initial begin
        bus_if.rdrf_clr = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_break();
        test_glitch();
        test_reset_mid_frame();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver: the downstream counterpart of the UART transmitter.
- Consumes the serial line, recovers bytes LSB-first at the same bit time, and presents each byte in a holding register.
- Holding register uses a receive-data-register-full (rdrf) flag plus sticky framing-error and overrun flags.
- Sits between the board RxD pin (or a transmitter TxD in loopback) and the byte-consuming control logic.

Parameters:
- BIT_TIME, 2600: clk cycles per serial bit. Legal range 4..4095; the counter is 12 bits.
- HALF_BIT, BIT_TIME/2: integer-truncated; cycles from start-edge detection to the start-bit mid-sample.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line, asynchronous to clk, idles high.
- rdrf_clr  input  1  single-cycle pulse from the consumer; acknowledges the byte and clears rdrf, fe and oe.
- rx_data  output  8  last correctly framed byte.
- rdrf  output  1  receive data register full.
- fe  output  1  sticky framing error.
- oe  output  1  sticky overrun.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (clr_n low, asynchronous):
  - state=IDLE, bit counter=0, baud counter=0, shift register=0.
  - Outputs: rx_data=0, rdrf=0, fe=0, oe=0, busy=0.
  - Synchroniser flops and the edge register reset to 1, so no false start edge at release.
  - A reset mid-frame abandons the frame; no flag is set.
- Input path:
  - rxd passes through a 2-FF synchroniser (rx_s), then an edge register (rx_d).
  - A start edge is rx_d=1 and rx_s=0, seen 3 clk after rxd falls.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: on a start edge, go to START with baud counter=0.
  - START: baud counter increments each cycle. At count HALF_BIT-1, evaluate the sample:
    - sample 0: go to DATA, baud counter=0, bit counter=0;
    - sample 1: glitch, return to IDLE with no flag change.
  - DATA: baud counter counts 0..BIT_TIME-1. At count BIT_TIME-1:
    - the sample is shifted into the shift register MSB, shifting right, so LSB-first reception ends aligned;
    - bit counter increments and the baud counter clears;
    - after the 8th sample (bit counter reaches 8), go to STOP.
  - STOP: baud counter counts 0..BIT_TIME-1, then samples and returns to IDLE.
    - Sample 1: rx_data <= shift register and rdrf <= 1. If rdrf was already 1 and rdrf_clr is not high this cycle, oe <= 1.
    - Sample 0: fe <= 1; rx_data and rdrf are unchanged.
  - After a stop sample of 0 (break), IDLE waits for rx_s to return high before a new start edge can occur.
- Timing:
  - Data bit k (k=0..7) is sampled HALF_BIT+(k+1)*BIT_TIME clk after START entry.
  - The stop bit is sampled at HALF_BIT+9*BIT_TIME clk after START entry.
  - rdrf/fe update on the next edge after the stop sample.
- Flag rules:
  - rdrf_clr clears rdrf, fe and oe on the next edge.
  - If a set and rdrf_clr occur in the same cycle, set wins. rdrf stays 1 and oe is not set, because the previous byte was acknowledged.
  - rdrf_clr never affects rx_data or the frame in progress.
- busy is asserted from the first START cycle through the last STOP cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - every decision point (start verify, each data bit, stop) uses a 2-of-3 majority of rx_s;
  - the three samples are taken on the decision cycle and the two preceding cycles;
  - requires BIT_TIME >= 6, checked by an elaboration-time assertion.
- Undefined: a single rx_s sample at the decision cycle, and no extra flops are instantiated.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding typedef (IDLE/START/DATA/STOP, 2 bits);
  - UART_BIT_TIME_DEFAULT=2600 and UART_DATA_BITS=8, which the transmitter also uses.
- One sub-module, uart_sync2: a parameterised-reset-value 2-FF synchroniser, reusable for other asynchronous inputs.

Test Plan:
- BIT_TIME=16. Send 0x55 as 8N1 with an idle gap:
  - rx_data=0x55;
  - rdrf rises exactly 3+8+144+1 clk after the rxd fall;
  - fe=0, oe=0, busy drops in the same cycle that rdrf rises.
- Send 0xA3 then 0x0F back-to-back with no rdrf_clr → rx_data=0x0F, rdrf=1, oe=1. Then pulse rdrf_clr → rdrf, fe and oe are all 0 next cycle.
- Send 0x3C with the stop bit forced low → fe=1, rdrf=0, rx_data keeps its prior value. With the line held low 40 bit-times, no new frame starts until rxd returns high.
- Drive a 4-clk low glitch on rxd in IDLE → START entered then IDLE; no flag change; rdrf=0.
- Assert clr_n low mid-frame after 4 bits, release, then send 0x81 → only 0x81 is received; fe=0, oe=0.
- With UART_RX_MAJORITY_EN, send 0xF0 with a 1-clk inverted spike on each bit's decision cycle → rx_data=0xF0, fe=0.
